// File: rtl/lsu_ctrl_pkg.sv
// Shared op codes, state encoding and decode helpers for the load/store unit.
// Optional feature macro (top level): LSU_BOUNDS_CHECK_EN.
package lsu_ctrl_pkg;

    localparam int DM_OP_BIT = 3;

    localparam logic [DM_OP_BIT-1:0] DM_OP_WD = 3'd0;
    localparam logic [DM_OP_BIT-1:0] DM_OP_UH = 3'd1;
    localparam logic [DM_OP_BIT-1:0] DM_OP_UB = 3'd2;
    localparam logic [DM_OP_BIT-1:0] DM_OP_SH = 3'd3;
    localparam logic [DM_OP_BIT-1:0] DM_OP_SB = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } lsu_state_e;

    function automatic logic dm_op_known(input logic [DM_OP_BIT-1:0] op);
        return (op == DM_OP_WD) || (op == DM_OP_UH) || (op == DM_OP_UB) ||
               (op == DM_OP_SH) || (op == DM_OP_SB);
    endfunction

    function automatic logic dm_misaligned(input logic [DM_OP_BIT-1:0] op,
                                           input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (op == DM_OP_WD)
            mis = (lo != 2'b00);
        else if ((op == DM_OP_UH) || (op == DM_OP_SH))
            mis = lo[0];
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatter: store lane enables / replication and load extraction.
// Purely combinational; undefined ops produce all-zero outputs.
module lsu_lane_fmt
    import lsu_ctrl_pkg::*;
(
    input  logic [DM_OP_BIT-1:0] op_i,
    input  logic [1:0]           addr_i,
    input  logic                 we_i,
    input  logic [31:0]          wdata_i,
    input  logic [31:0]          rdata_i,
    output logic [3:0]           be_o,
    output logic [31:0]          wdata_o,
    output logic [31:0]          rdata_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata_i[{addr_i, 3'b000} +: 8];
    assign rd_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        unique case (op_i)
            DM_OP_WD: begin
                be_o    = we_i ? 4'b1111 : 4'b0000;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            DM_OP_SH: begin
                be_o    = !we_i ? 4'b0000 : (addr_i[1] ? 4'b1100 : 4'b0011);
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{rd_half[15]}}, rd_half};
            end
            DM_OP_UH: begin
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, rd_half};
            end
            DM_OP_SB: begin
                be_o    = we_i ? (4'b0001 << addr_i) : 4'b0000;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{rd_byte[7]}}, rd_byte};
            end
            DM_OP_UB: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, rd_byte};
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store initiator toward a fixed-latency byte-laned memory.
// Define LSU_BOUNDS_CHECK_EN to fault accesses outside the 2^ADDR_W window.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DM_OP_BIT-1:0] req_op,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 stall,
    output logic                 addr_err,
    output logic [31:0]          err_badvaddr,
    output logic                 err_is_store,
    output logic                 mem_en,
    output logic [3:0]           mem_be,
    output logic [ADDR_W-3:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    lsu_state_e           state_q, state_d;
    logic                 we_q, we_d;
    logic [DM_OP_BIT-1:0] op_q, op_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_rdata;
    logic [31:0] resp_data;
    logic        req_mis;
    logic        req_oob;

    lsu_lane_fmt u_fmt (
        .op_i    (op_q),
        .addr_i  (addr_q[1:0]),
        .we_i    (we_q),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata),
        .be_o    (fmt_be),
        .wdata_o (fmt_wdata),
        .rdata_o (fmt_rdata)
    );

    assign req_mis = dm_misaligned(req_op, req_addr[1:0]);
`ifdef LSU_BOUNDS_CHECK_EN
    assign req_oob = |req_addr[31:ADDR_W];
`else
    assign req_oob = 1'b0;
`endif

    // Read word arrives in the RESP cycle; it is latched there for holding.
    assign resp_data = (we_q || !dm_op_known(op_q)) ? 32'h0 : fmt_rdata;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (req_mis || req_oob)
                        state_d = ST_ERR;
                    else if (!dm_op_known(req_op))
                        state_d = ST_RESP;
                    else
                        state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CW'(MEM_LAT - 1))
                    state_d = ST_RESP;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_RESP: begin
                rdata_d = resp_data;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            op_q    <= DM_OP_WD;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign stall        = ((state_q == ST_IDLE) && req_valid) ||
                          (state_q == ST_ACCESS);
    assign mem_en       = (state_q == ST_ACCESS);
    assign mem_be       = mem_en ? fmt_be : 4'b0000;
    assign mem_addr     = addr_q[ADDR_W-1:2];
    assign mem_wdata    = fmt_wdata;
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_rdata   = (state_q == ST_RESP) ? resp_data : rdata_q;
    assign addr_err     = (state_q == ST_ERR);
    assign err_badvaddr = addr_q;
    assign err_is_store = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table on a MEM_LAT=1 instance,
// latency and mid-access reset sequences on a MEM_LAT=3 instance.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int AW = 12;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        en;
        logic [3:0]  be;
        logic [31:0] mw;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic        done;
        logic        resp;
        logic        err;
        int          cyc;
        int          en_n;
        logic [3:0]  be;
        logic [31:0] mw;
        logic [9:0]  ma;
        logic [31:0] rd;
        logic [31:0] bv;
        logic        st;
        logic        stall0;
        logic        ready0;
    } obs_t;

    logic clk, rst, preload;
    logic req_we;
    logic [2:0] req_op;
    logic [31:0] req_addr, req_wdata;

    logic rv1, rdy1, resp_valid1, stall1, addr_err1, is_st1, mem_en1;
    logic [31:0] resp_rdata1, badv1, mem_wdata1, mem_rdata1;
    logic [3:0] mem_be1;
    logic [9:0] mem_addr1;

    logic rv3, rdy3, resp_valid3, stall3, addr_err3, is_st3, mem_en3;
    logic [31:0] resp_rdata3, badv3, mem_wdata3, mem_rdata3;
    logic [3:0] mem_be3;
    logic [9:0] mem_addr3;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    int cnt1, cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_ctrl #(.MEM_LAT(1), .ADDR_W(AW)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
        .stall(stall1), .addr_err(addr_err1),
        .err_badvaddr(badv1), .err_is_store(is_st1),
        .mem_en(mem_en1), .mem_be(mem_be1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    lsu_ctrl #(.MEM_LAT(3), .ADDR_W(AW)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(rv3), .req_ready(rdy3), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
        .stall(stall3), .addr_err(addr_err3),
        .err_badvaddr(badv3), .err_is_store(is_st3),
        .mem_en(mem_en3), .mem_be(mem_be3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models commit writes / sample reads on the last strobe cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1 <= 0;
            if (preload) begin
                for (int i = 0; i < 1024; i++) mem1[i] <= 32'h0;
                mem1[0] <= 32'h12345678;
            end
        end else if (mem_en1) begin
            if (cnt1 == 0) begin
                mem_rdata1 <= mem1[mem_addr1];
                for (int b = 0; b < 4; b++)
                    if (mem_be1[b])
                        mem1[mem_addr1][8*b +: 8] <= mem_wdata1[8*b +: 8];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt3 <= 0;
            if (preload) begin
                for (int i = 0; i < 1024; i++) mem3[i] <= 32'h0;
                mem3[4] <= 32'hCAFEF00D;
            end
        end else if (mem_en3) begin
            if (cnt3 == 2) begin
                cnt3 <= 0;
                mem_rdata3 <= mem3[mem_addr3];
                for (int b = 0; b < 4; b++)
                    if (mem_be3[b])
                        mem3[mem_addr3][8*b +: 8] <= mem_wdata3[8*b +: 8];
            end else begin
                cnt3 <= cnt3 + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic err, input logic en,
                                input logic [3:0] be, input logic [31:0] mw,
                                input logic [31:0] rd);
        vec_t v;
        v.we = we; v.op = op; v.addr = a; v.wdata = wd;
        v.err = err; v.en = en; v.be = be; v.mw = mw; v.rd = rd;
        return v;
    endfunction

    task automatic apply1(input vec_t v, output obs_t o);
        o = '{default: '0};
        @(negedge clk);
        req_we = v.we; req_op = v.op;
        req_addr = v.addr; req_wdata = v.wdata;
        rv1 = 1'b1;
        #1;
        o.stall0 = stall1;
        o.ready0 = rdy1;
        @(posedge clk);
        for (int c = 1; c <= 20 && !o.done; c++) begin
            @(negedge clk);
            rv1 = 1'b0;
            if (mem_en1) begin
                o.en_n++;
                o.be = mem_be1; o.mw = mem_wdata1; o.ma = mem_addr1;
            end
            if (resp_valid1) begin
                o.done = 1'b1; o.resp = 1'b1; o.cyc = c; o.rd = resp_rdata1;
            end
            if (addr_err1) begin
                o.done = 1'b1; o.err = 1'b1; o.cyc = c;
                o.bv = badv1; o.st = is_st1;
            end
        end
    endtask

    vec_t vt [20];
    obs_t ob;
    int   st_n, en_n, rsp_c, rsp_n;
    logic [31:0] rsp_d;

    initial begin
        rst = 1'b1; preload = 1'b1;
        rv1 = 1'b0; rv3 = 1'b0;
        req_we = 1'b0; req_op = DM_OP_WD; req_addr = 0; req_wdata = 0;

        vt[0]  = mk(1, DM_OP_WD, 32'h010, 32'hDEADBEEF, 0, 1, 4'hF, 32'hDEADBEEF, 0);
        vt[1]  = mk(0, DM_OP_WD, 32'h010, 0, 0, 1, 0, 0, 32'hDEADBEEF);
        vt[2]  = mk(1, DM_OP_SB, 32'h013, 32'hA5, 0, 1, 4'h8, 32'hA5A5A5A5, 0);
        vt[3]  = mk(0, DM_OP_SB, 32'h013, 0, 0, 1, 0, 0, 32'hFFFFFFA5);
        vt[4]  = mk(0, DM_OP_UB, 32'h013, 0, 0, 1, 0, 0, 32'h000000A5);
        vt[5]  = mk(1, DM_OP_SH, 32'h016, 32'h8001, 0, 1, 4'hC, 32'h80018001, 0);
        vt[6]  = mk(0, DM_OP_SH, 32'h016, 0, 0, 1, 0, 0, 32'hFFFF8001);
        vt[7]  = mk(0, DM_OP_UH, 32'h016, 0, 0, 1, 0, 0, 32'h00008001);
        vt[8]  = mk(0, DM_OP_WD, 32'h011, 0, 1, 0, 0, 0, 0);
        vt[9]  = mk(1, DM_OP_SH, 32'h021, 32'h1234, 1, 0, 0, 0, 0);
        vt[10] = mk(0, DM_OP_WD, 32'h020, 0, 0, 1, 0, 0, 32'h0);
        vt[11] = mk(0, 3'd7,     32'h010, 0, 0, 0, 0, 0, 32'h0);
        vt[12] = mk(0, DM_OP_SB, 32'h010, 0, 0, 1, 0, 0, 32'hFFFFFFEF);
        vt[13] = mk(0, DM_OP_UH, 32'h012, 0, 0, 1, 0, 0, 32'h0000A5AD);
        vt[14] = mk(0, DM_OP_SH, 32'h010, 0, 0, 1, 0, 0, 32'hFFFFBEEF);
        vt[15] = mk(1, DM_OP_SB, 32'h011, 32'h12345677, 0, 1, 4'h2, 32'h77777777, 0);
        vt[16] = mk(0, DM_OP_UB, 32'h011, 0, 0, 1, 0, 0, 32'h00000077);
        vt[17] = mk(0, DM_OP_WD, 32'h012, 0, 1, 0, 0, 0, 0);
`ifdef LSU_BOUNDS_CHECK_EN
        vt[18] = mk(0, DM_OP_WD, 32'h1000, 0, 1, 0, 0, 0, 0);
`else
        vt[18] = mk(0, DM_OP_WD, 32'h1000, 0, 0, 1, 0, 0, 32'h12345678);
`endif
        vt[19] = mk(0, DM_OP_WD, 32'h010, 0, 0, 1, 0, 0, 32'hA5AD77EF);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; preload = 1'b0;
        #1;
        chk("rst mem_en", {31'h0, mem_en1}, 0);
        chk("rst mem_be", {28'h0, mem_be1}, 0);
        chk("rst mem_addr", {22'h0, mem_addr1}, 0);
        chk("rst mem_wdata", mem_wdata1, 0);
        chk("rst resp_valid", {31'h0, resp_valid1}, 0);
        chk("rst resp_rdata", resp_rdata1, 0);
        chk("rst addr_err", {31'h0, addr_err1}, 0);
        chk("rst badvaddr", badv1, 0);
        chk("rst is_store", {31'h0, is_st1}, 0);
        chk("rst ready", {31'h0, rdy1}, 1);
        chk("rst stall", {31'h0, stall1}, 0);

        for (int i = 0; i < 20; i++) begin
            apply1(vt[i], ob);
            chk($sformatf("v%0d stall", i), {31'h0, ob.stall0}, 1);
            chk($sformatf("v%0d ready", i), {31'h0, ob.ready0}, 1);
            chk($sformatf("v%0d done", i), {31'h0, ob.done}, 1);
            chk($sformatf("v%0d en_cycles", i), ob.en_n, {31'h0, vt[i].en});
            chk($sformatf("v%0d err", i), {31'h0, ob.err}, {31'h0, vt[i].err});
            chk($sformatf("v%0d latency", i), ob.cyc,
                (vt[i].en ? 2 : 1));
            if (vt[i].err) begin
                chk($sformatf("v%0d badvaddr", i), ob.bv, vt[i].addr);
                chk($sformatf("v%0d is_store", i), {31'h0, ob.st},
                    {31'h0, vt[i].we});
            end else begin
                chk($sformatf("v%0d rdata", i), ob.rd, vt[i].rd);
                if (vt[i].en)
                    chk($sformatf("v%0d mem_addr", i), {22'h0, ob.ma},
                        {22'h0, vt[i].addr[11:2]});
                if (vt[i].en && vt[i].we) begin
                    chk($sformatf("v%0d mem_be", i), {28'h0, ob.be},
                        {28'h0, vt[i].be});
                    chk($sformatf("v%0d mem_wdata", i), ob.mw, vt[i].mw);
                end
            end
        end
        chk("mem word8 untouched", mem1[8], 32'h0);

        // MEM_LAT=3 load: stall 4 cycles, strobe 3, response in 5th cycle.
        @(negedge clk);
        req_we = 1'b0; req_op = DM_OP_WD; req_addr = 32'h010; rv3 = 1'b1;
        #1;
        st_n = stall3 ? 1 : 0;
        en_n = 0; rsp_c = 0; rsp_d = 0;
        @(posedge clk);
        for (int c = 1; c <= 20 && rsp_c == 0; c++) begin
            @(negedge clk);
            rv3 = 1'b0;
            if (stall3) st_n++;
            if (mem_en3) en_n++;
            if (resp_valid3) begin rsp_c = c; rsp_d = resp_rdata3; end
        end
        chk("lat3 stall cycles", st_n, 4);
        chk("lat3 mem_en cycles", en_n, 3);
        chk("lat3 resp cycle", rsp_c, 4);
        chk("lat3 rdata", rsp_d, 32'hCAFEF00D);

        // Reset during the second strobe cycle of a store.
        @(negedge clk);
        req_we = 1'b1; req_op = DM_OP_WD;
        req_addr = 32'h010; req_wdata = 32'h11111111; rv3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv3 = 1'b0;
        chk("rst3 en c1", {31'h0, mem_en3}, 1);
        @(negedge clk);
        chk("rst3 en c2", {31'h0, mem_en3}, 1);
        chk("rst3 be c2", {28'h0, mem_be3}, 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("rst3 en drop", {31'h0, mem_en3}, 0);
        chk("rst3 be drop", {28'h0, mem_be3}, 0);
        chk("rst3 ready", {31'h0, rdy3}, 1);
        @(negedge clk);
        rst = 1'b0;
        rsp_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid3 || mem_en3) rsp_n++;
        end
        chk("rst3 no activity", rsp_n, 0);
        chk("rst3 word kept", mem3[4], 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
